// File: rtl/branch_pred.sv
// Fetch-stage branch predictor: direct-mapped BTB with a 2-bit saturating counter per entry.
// Lookup is combinational from pc_i; EX resolutions train the table on the clock edge.
module branch_pred #(
    parameter int IDX_W = 4,
    parameter int TAG_W = 8,
    parameter int CNT_W = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [31:0]               pc_i,
    input  logic                      fetch_valid,
    output logic [31:0]               pre_pc,
    output logic                      pred_taken,
    output logic                      pred_hit,
    input  logic                      upd_valid,
    input  logic [31:0]               upd_pc,
    input  logic                      upd_taken,
    input  logic [31:0]               upd_target,
    input  logic                      upd_mispred,
    output logic [CNT_W-1:0]          stat_pred,
    output logic [CNT_W-1:0]          stat_mispred,
    output logic [(1<<IDX_W)-1:0]     dbg_valid,
    output logic [2*(1<<IDX_W)-1:0]   dbg_ctr
);
    localparam int ENTRIES = 1 << IDX_W;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } ctr_e;

    logic             valid_q  [ENTRIES];
    ctr_e             ctr_q    [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];

    logic [IDX_W-1:0] look_idx;
    logic [TAG_W-1:0] look_tag;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;
    logic             unused_bits;

    function automatic ctr_e sat_inc(input ctr_e c);
        case (c)
            STRONG_NT: return WEAK_NT;
            WEAK_NT:   return WEAK_T;
            default:   return STRONG_T;
        endcase
    endfunction

    function automatic ctr_e sat_dec(input ctr_e c);
        case (c)
            STRONG_T: return WEAK_T;
            WEAK_T:   return WEAK_NT;
            default:  return STRONG_NT;
        endcase
    endfunction

    assign look_idx = pc_i[IDX_W+1:2];
    assign look_tag = pc_i[IDX_W+TAG_W+1:IDX_W+2];
    assign upd_idx  = upd_pc[IDX_W+1:2];
    assign upd_tag  = upd_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign upd_hit  = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    assign unused_bits = ^{pc_i[1:0], pc_i[31:IDX_W+TAG_W+2],
                           upd_pc[1:0], upd_pc[31:IDX_W+TAG_W+2]};

    // Lookup reads registered state only, so a same-cycle update is seen next cycle.
    always_comb begin
        pred_hit   = !reset && valid_q[look_idx] && (tag_q[look_idx] == look_tag);
        pred_taken = pred_hit && ctr_q[look_idx][1];
        pre_pc     = pred_taken ? target_q[look_idx] : pc_i + 32'd4;
    end

    always_comb begin
        dbg_valid = '0;
        dbg_ctr   = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            dbg_valid[i]       = valid_q[i];
            dbg_ctr[2*i +: 2]  = ctr_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= WEAK_NT;
            end
            stat_pred    <= '0;
            stat_mispred <= '0;
        end else begin
            if (fetch_valid && pred_taken)
                stat_pred <= stat_pred + CNT_W'(1);
            if (upd_valid && upd_mispred)
                stat_mispred <= stat_mispred + CNT_W'(1);
            if (upd_valid) begin
                if (upd_hit) begin
                    ctr_q[upd_idx] <= upd_taken ? sat_inc(ctr_q[upd_idx])
                                                : sat_dec(ctr_q[upd_idx]);
                end else if (upd_taken) begin
                    valid_q[upd_idx] <= 1'b1;
                    ctr_q[upd_idx]   <= WEAK_T;
                end
            end
        end
    end

    // Tag and target need no reset: they are only trusted behind valid.
    always_ff @(posedge clk) begin
        if (!reset && upd_valid && upd_taken) begin
            tag_q[upd_idx]    <= upd_tag;
            target_q[upd_idx] <= upd_target;
        end
    end

endmodule

// File: tb/tb_branch_pred.sv
// Randomised and directed bench for branch_pred against a table-level reference model.
module tb_branch_pred;
    localparam int CNT_W = 8;
    localparam int N     = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [31:0]       pc_i;
    logic              fetch_valid;
    logic [31:0]       pre_pc;
    logic              pred_taken;
    logic              pred_hit;
    logic              upd_valid;
    logic [31:0]       upd_pc;
    logic              upd_taken;
    logic [31:0]       upd_target;
    logic              upd_mispred;
    logic [CNT_W-1:0]  stat_pred;
    logic [CNT_W-1:0]  stat_mispred;
    logic [N-1:0]      dbg_valid;
    logic [2*N-1:0]    dbg_ctr;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model: one record per BTB slot, counter kept as an integer 0..3
    bit          m_valid  [N];
    int unsigned m_tag    [N];
    logic [31:0] m_target [N];
    int          m_ctr    [N];
    int unsigned m_stat_pred;
    int unsigned m_stat_mispred;

    branch_pred #(.IDX_W(4), .TAG_W(8), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .pc_i(pc_i), .fetch_valid(fetch_valid),
        .pre_pc(pre_pc), .pred_taken(pred_taken), .pred_hit(pred_hit),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_mispred(upd_mispred),
        .stat_pred(stat_pred), .stat_mispred(stat_mispred),
        .dbg_valid(dbg_valid), .dbg_ctr(dbg_ctr)
    );

    always #5 clk = ~clk;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % 16);
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return (pc >> 6) % 256;
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return !reset && m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
    endfunction

    function automatic bit m_taken(input logic [31:0] pc);
        return m_hit(pc) && (m_ctr[idx_of(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_pre(input logic [31:0] pc);
        return m_taken(pc) ? m_target[idx_of(pc)] : pc + 32'd4;
    endfunction

    function automatic logic [N-1:0] m_valid_vec();
        logic [N-1:0] v = '0;
        for (int i = 0; i < N; i++) v[i] = m_valid[i];
        return v;
    endfunction

    function automatic logic [2*N-1:0] m_ctr_vec();
        logic [2*N-1:0] v = '0;
        for (int i = 0; i < N; i++) v[2*i +: 2] = 2'(m_ctr[i]);
        return v;
    endfunction

    // one clock: model samples the same inputs the DUT sees at the edge
    task automatic tick();
        int u;
        bit t;
        @(posedge clk);
        t = m_taken(pc_i);
        u = idx_of(upd_pc);
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                m_valid[i] = 0;
                m_ctr[i]   = 1;
            end
            m_stat_pred    = 0;
            m_stat_mispred = 0;
        end else begin
            if (fetch_valid && t) m_stat_pred = (m_stat_pred + 1) % 256;
            if (upd_valid && upd_mispred) m_stat_mispred = (m_stat_mispred + 1) % 256;
            if (upd_valid) begin
                if (m_valid[u] && m_tag[u] == tag_of(upd_pc)) begin
                    if (upd_taken) begin
                        m_ctr[u]    = (m_ctr[u] == 3) ? 3 : m_ctr[u] + 1;
                        m_target[u] = upd_target;
                    end else begin
                        m_ctr[u] = (m_ctr[u] == 0) ? 0 : m_ctr[u] - 1;
                    end
                end else if (upd_taken) begin
                    m_valid[u]  = 1;
                    m_tag[u]    = tag_of(upd_pc);
                    m_target[u] = upd_target;
                    m_ctr[u]    = 2;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic drive_upd(input bit v, input logic [31:0] pc, input bit tk,
                             input logic [31:0] tgt, input bit mp);
        upd_valid   = v;
        upd_pc      = pc;
        upd_taken   = tk;
        upd_target  = tgt;
        upd_mispred = mp;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        fetch_valid = 1'b1;
        pc_i = 32'h40;
        drive_upd(1, 32'h40, 1, 32'h100, 1);
        #1;
        n_checks++;
        if (pre_pc !== 32'h44 || pred_hit !== 1'b0 || pred_taken !== 1'b0)
            $display("FAIL reset_lookup pre_pc=%h hit=%b taken=%b want 00000044 0 0", pre_pc, pred_hit, pred_taken);
        else n_pass++;
        tick();
        tick();
        reset = 1'b0;
        drive_upd(0, 0, 0, 0, 0);
        #1;
        n_checks++;
        if (dbg_valid !== '0 || dbg_ctr !== 32'h5555_5555)
            $display("FAIL reset_table valid=%h ctr=%h want 0000 55555555", dbg_valid, dbg_ctr);
        else n_pass++;
        n_checks++;
        if (stat_pred !== '0 || stat_mispred !== '0)
            $display("FAIL reset_stats pred=%0d mispred=%0d want 0 0", stat_pred, stat_mispred);
        else n_pass++;
        n_checks++;
        if (pre_pc !== 32'h44 || pred_hit !== 1'b0 || pred_taken !== 1'b0)
            $display("FAIL post_reset_lookup pre_pc=%h hit=%b taken=%b want 00000044 0 0", pre_pc, pred_hit, pred_taken);
        else n_pass++;
    endtask

    task automatic test_train();
        pc_i = 32'h40;
        drive_upd(1, 32'h40, 1, 32'h100, 0);
        tick();
        drive_upd(0, 0, 0, 0, 0);
        #1;
        n_checks++;
        if (pre_pc !== 32'h100 || pred_hit !== 1'b1 || pred_taken !== 1'b1 || dbg_ctr[1:0] !== 2'b10)
            $display("FAIL alloc pre_pc=%h hit=%b taken=%b ctr=%b want 00000100 1 1 10", pre_pc, pred_hit, pred_taken, dbg_ctr[1:0]);
        else n_pass++;
        for (int k = 0; k < 3; k++) begin
            drive_upd(1, 32'h40, 0, 32'h999, 1);
            tick();
            drive_upd(0, 0, 0, 0, 0);
            #1;
            n_checks++;
            if (dbg_ctr[1:0] !== ((k == 0) ? 2'b01 : 2'b00) || pre_pc !== 32'h44 || pred_hit !== 1'b1)
                $display("FAIL not_taken_%0d ctr=%b pre_pc=%h hit=%b want %b 00000044 1", k, dbg_ctr[1:0], pre_pc, pred_hit, (k == 0) ? 2'b01 : 2'b00);
            else n_pass++;
        end
        n_checks++;
        if (stat_mispred !== CNT_W'(m_stat_mispred) || stat_pred !== CNT_W'(m_stat_pred))
            $display("FAIL train_stats pred=%0d mispred=%0d want %0d %0d", stat_pred, stat_mispred, m_stat_pred, m_stat_mispred);
        else n_pass++;
    endtask

    task automatic test_same_cycle();
        pc_i = 32'h80;
        drive_upd(1, 32'h80, 1, 32'h200, 0);
        #1;
        n_checks++;
        if (pre_pc !== 32'h84 || pred_hit !== 1'b0)
            $display("FAIL same_cycle_old pre_pc=%h hit=%b want 00000084 0", pre_pc, pred_hit);
        else n_pass++;
        tick();
        drive_upd(0, 0, 0, 0, 0);
        #1;
        n_checks++;
        if (pre_pc !== 32'h200 || pred_taken !== 1'b1)
            $display("FAIL same_cycle_new pre_pc=%h taken=%b want 00000200 1", pre_pc, pred_taken);
        else n_pass++;
    endtask

    task automatic test_alias();
        drive_upd(1, 32'h40, 1, 32'h100, 0);
        tick();
        drive_upd(1, 32'h440, 1, 32'h300, 0);
        tick();
        drive_upd(1, 32'h40, 0, 32'h0, 0);
        tick();
        drive_upd(0, 0, 0, 0, 0);
        pc_i = 32'h40;
        #1;
        n_checks++;
        if (pre_pc !== 32'h44 || pred_hit !== 1'b0)
            $display("FAIL alias_old pre_pc=%h hit=%b want 00000044 0", pre_pc, pred_hit);
        else n_pass++;
        pc_i = 32'h440;
        #1;
        n_checks++;
        if (pre_pc !== 32'h300 || pred_hit !== 1'b1 || dbg_ctr[1:0] !== 2'b10)
            $display("FAIL alias_new pre_pc=%h hit=%b ctr=%b want 00000300 1 10", pre_pc, pred_hit, dbg_ctr[1:0]);
        else n_pass++;
        tick();
    endtask

    task automatic test_pc_wrap();
        pc_i = 32'hFFFF_FFFC;
        #1;
        n_checks++;
        if (pre_pc !== 32'h0 || pred_hit !== 1'b0)
            $display("FAIL pc_wrap pre_pc=%h hit=%b want 00000000 0", pre_pc, pred_hit);
        else n_pass++;
        tick();
    endtask

    task automatic test_stat_wrap();
        int budget = 400;
        fetch_valid = 1'b0;
        drive_upd(1, 32'h1000, 0, 32'h0, 1);
        while (m_stat_mispred != 255 && budget > 0) begin
            tick();
            budget--;
        end
        drive_upd(0, 0, 0, 0, 0);
        #1;
        n_checks++;
        if (stat_mispred !== 8'hFF)
            $display("FAIL mispred_max got %0d want 255 (budget left %0d)", stat_mispred, budget);
        else n_pass++;
        drive_upd(1, 32'h1000, 0, 32'h0, 1);
        tick();
        drive_upd(0, 0, 0, 0, 0);
        #1;
        n_checks++;
        if (stat_mispred !== 8'h00)
            $display("FAIL mispred_wrap got %0d want 0", stat_mispred);
        else n_pass++;
        fetch_valid = 1'b1;
    endtask

    task automatic test_random();
        logic [31:0] p;
        for (int c = 0; c < 400; c++) begin
            p = {$urandom_range(0, 3), 6'b0} | {$urandom_range(0, 15), 2'b00};
            if ($urandom_range(0, 7) == 0) p = {$urandom} & 32'hFFFF_FFFC;
            pc_i = p;
            fetch_valid = 1'($urandom_range(0, 3) != 0);
            p = {$urandom_range(0, 3), 6'b0} | {$urandom_range(0, 15), 2'b00};
            drive_upd(1'($urandom_range(0, 1)), p, 1'($urandom_range(0, 2) != 0),
                      {$urandom} & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)));
            #1;
            n_checks++;
            if (pre_pc !== m_pre(pc_i) || pred_hit !== m_hit(pc_i) || pred_taken !== m_taken(pc_i))
                $display("FAIL rand_lookup pc=%h pre_pc=%h hit=%b taken=%b want %h %b %b", pc_i, pre_pc, pred_hit, pred_taken, m_pre(pc_i), m_hit(pc_i), m_taken(pc_i));
            else n_pass++;
            tick();
            n_checks++;
            if (dbg_valid !== m_valid_vec() || dbg_ctr !== m_ctr_vec() ||
                stat_pred !== CNT_W'(m_stat_pred) || stat_mispred !== CNT_W'(m_stat_mispred))
                $display("FAIL rand_state valid=%h ctr=%h sp=%0d sm=%0d want %h %h %0d %0d", dbg_valid, dbg_ctr, stat_pred, stat_mispred, m_valid_vec(), m_ctr_vec(), m_stat_pred, m_stat_mispred);
            else n_pass++;
        end
        drive_upd(0, 0, 0, 0, 0);
    endtask

    task automatic test_reset_dominates();
        reset = 1'b1;
        drive_upd(1, 32'h7C, 1, 32'h500, 1);
        tick();
        reset = 1'b0;
        drive_upd(0, 0, 0, 0, 0);
        pc_i = 32'h7C;
        #1;
        n_checks++;
        if (dbg_valid !== '0 || dbg_ctr !== 32'h5555_5555 || stat_mispred !== '0 || pre_pc !== 32'h80)
            $display("FAIL reset_dominates valid=%h ctr=%h sm=%0d pre_pc=%h want 0000 55555555 0 00000080", dbg_valid, dbg_ctr, stat_mispred, pre_pc);
        else n_pass++;
    endtask

    initial begin
        reset = 1'b1;
        pc_i = '0;
        fetch_valid = 1'b0;
        drive_upd(0, 0, 0, 0, 0);
        @(negedge clk);
        test_reset();
        test_train();
        test_same_cycle();
        test_alias();
        test_pc_wrap();
        test_stat_wrap();
        test_random();
        test_reset_dominates();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
